schmitt_trigger_bank: RTL

SCHMITT_TRIGGER_BANK -- requirements
Module: schmitt_trigger_bank

---
 rtl/schmitt_trigger_bank.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/schmitt_trigger_bank.sv
// Multi-channel debounce / hysteresis filter.
// Each raw input bit is synchronised. A small per-channel FSM then requires a
// run of consecutive agreeing samples before it changes the filtered level.
// Sampling is paced by a shared prescaler tick.
module schmitt_trigger_bank #(
  parameter int p_channels   = 4,
  parameter int p_rise_count = 5,
  parameter int p_fall_count = 5,
  parameter int p_prescale   = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [p_channels-1:0] i_in,
  output logic [p_channels-1:0] o_out,
  output logic [p_channels-1:0] o_rise,
  output logic [p_channels-1:0] o_fall,
  output logic                  o_ready
);

  localparam int c_max   = (p_rise_count > p_fall_count) ? p_rise_count : p_fall_count;
  localparam int c_cnt_w = $clog2(c_max + 1);
  localparam int c_pre_w = (p_prescale > 1) ? $clog2(p_prescale) : 1;

  localparam logic [c_cnt_w-1:0] c_rise_last = c_cnt_w'(p_rise_count - 1);
  localparam logic [c_cnt_w-1:0] c_fall_last = c_cnt_w'(p_fall_count - 1);
  localparam logic [c_cnt_w-1:0] c_one       = c_cnt_w'(1);
  localparam logic [c_pre_w-1:0] c_pre_last  = c_pre_w'(p_prescale - 1);

  typedef enum logic [2:0] {
    st_start = 3'd0,
    st_low   = 3'd1,
    st_rise  = 3'd2,
    st_high  = 3'd3,
    st_fall  = 3'd4
  } state_t;

  logic [p_channels-1:0] sync_q1;
  logic [p_channels-1:0] sync_s;
  logic [1:0]            primed_q;
  logic [c_pre_w-1:0]    pre_cnt;
  logic                  tick;

  state_t               state_q [p_channels];
  state_t               state_d [p_channels];
  logic [c_cnt_w-1:0]   cnt_q   [p_channels];
  logic [c_cnt_w-1:0]   cnt_d   [p_channels];
  logic [p_channels-1:0] out_d;
  logic [p_channels-1:0] rise_d;
  logic [p_channels-1:0] fall_d;
  logic                  ready_d;

  // Two-flop synchroniser per channel; only sync_s feeds the filter.
  // NOTE: reset here is synchronous and active-high, so it sits inside the
  // clocked branch with top priority instead of in the sensitivity list.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q1 <= '0;
      sync_s  <= '0;
    end else begin
      // NOTE: non-blocking assignments make sync_s take the *old* sync_q1, which
      // is what builds the two-stage chain; blocking here would collapse it.
      sync_q1 <= i_in;
      sync_s  <= sync_q1;
    end
  end

  // The synchroniser is flushed to 0 by reset. START waits until two real
  // samples have been shifted through, so its first decision reflects the
  // actual input and not the reset value.
  always_ff @(posedge i_clk) begin
    if (i_rst) primed_q <= 2'b00;
    else       primed_q <= {primed_q[0], 1'b1};
  end

  // Shared sample-tick prescaler: counts 0..p_prescale-1 and ticks on the last value.
  assign tick = (pre_cnt == c_pre_last);

  always_ff @(posedge i_clk) begin
    if (i_rst)     pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + c_pre_w'(1);
  end

  // Per-channel next-state, counter, and edge-pulse decode.
  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so
    // no path leaves a value unassigned and no latch is inferred.
    out_d   = '0;
    rise_d  = '0;
    fall_d  = '0;
    ready_d = 1'b1;
    for (int ch = 0; ch < p_channels; ch++) begin
      state_d[ch] = state_q[ch];
      cnt_d[ch]   = cnt_q[ch];
      if (tick) begin
        case (state_q[ch])
          st_start: begin
            if (primed_q[1]) begin
              state_d[ch] = sync_s[ch] ? st_high : st_low;
              cnt_d[ch]   = '0;
            end
          end
          st_low: begin
            cnt_d[ch] = '0;
            if (sync_s[ch]) begin
              if (p_rise_count == 1) begin
                state_d[ch] = st_high;
                rise_d[ch]  = 1'b1;
              end else begin
                state_d[ch] = st_rise;
                cnt_d[ch]   = c_one;
              end
            end
          end
          st_rise: begin
            if (!sync_s[ch]) begin
              state_d[ch] = st_low;
              cnt_d[ch]   = '0;
            end else if (cnt_q[ch] == c_rise_last) begin
              state_d[ch] = st_high;
              cnt_d[ch]   = '0;
              rise_d[ch]  = 1'b1;
            end else begin
              cnt_d[ch] = cnt_q[ch] + c_one;
            end
          end
          st_high: begin
            cnt_d[ch] = '0;
            if (!sync_s[ch]) begin
              if (p_fall_count == 1) begin
                state_d[ch] = st_low;
                fall_d[ch]  = 1'b1;
              end else begin
                state_d[ch] = st_fall;
                cnt_d[ch]   = c_one;
              end
            end
          end
          st_fall: begin
            if (sync_s[ch]) begin
              state_d[ch] = st_high;
              cnt_d[ch]   = '0;
            end else if (cnt_q[ch] == c_fall_last) begin
              state_d[ch] = st_low;
              cnt_d[ch]   = '0;
              fall_d[ch]  = 1'b1;
            end else begin
              cnt_d[ch] = cnt_q[ch] + c_one;
            end
          end
          default: begin
            state_d[ch] = st_start;
            cnt_d[ch]   = '0;
          end
        endcase
      end
      out_d[ch] = (state_d[ch] == st_high) || (state_d[ch] == st_fall);
      if (state_d[ch] == st_start) ready_d = 1'b0;
    end
  end

  // Channel state and counters, plus registered outputs that follow the new state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int ch = 0; ch < p_channels; ch++) begin
        state_q[ch] <= st_start;
        cnt_q[ch]   <= '0;
      end
      o_out   <= '0;
      o_rise  <= '0;
      o_fall  <= '0;
      o_ready <= 1'b0;
    end else begin
      for (int ch = 0; ch < p_channels; ch++) begin
        state_q[ch] <= state_d[ch];
        cnt_q[ch]   <= cnt_d[ch];
      end
      o_out   <= out_d;
      o_rise  <= rise_d;
      o_fall  <= fall_d;
      o_ready <= ready_d;
    end
  end

endmodule
